bf_tape_mem: RTL and testbench

Data-tape memory serving the brainfuck core's mem_* request port. It holds 2**logsize 8-bit cells and accepts single-beat reads and writes. Reads return after one cycle. After each accepted write it holds busy for a fixed recovery window. On mem_init it runs a hardware zero-sweep of the whole tape. It sits directly downstream of the core, and its outputs drive the core's mem_busy, mem_rvalid and mem_rdata inputs.

---
 rtl/bf_pkg.sv | 10 +
 rtl/bf_tape_ram.sv | 29 ++
 rtl/bf_tape_mem.sv | 110 +++++++++++
 tb/tb_bf_tape_mem.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck core and its data-tape memory.
package bf_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_WBUSY = 2'd2
  } state_e;

  localparam int CWIDTH = 8;
endpackage

// File: rtl/bf_tape_ram.sv
// Single-port synchronous tape RAM; read data is registered and holds between reads.
module bf_tape_ram
  import bf_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [CWIDTH-1:0] wdata_i,
  output logic [CWIDTH-1:0] rdata_o
);
  logic [CWIDTH-1:0] mem_q [2**AW];
  logic [CWIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Only the read register is reset; the array contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/bf_tape_mem.sv
// Data-tape controller: pipelined reads, write recovery window, and hardware zero-sweep.
module bf_tape_mem
  import bf_pkg::*;
#(
  parameter int logsize = 7,
  parameter int wr_busy = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_init,
  input  logic [logsize-1:0] mem_addr,
  input  logic [CWIDTH-1:0]  mem_wdata,
  input  logic               mem_wselect,
  input  logic               mem_doit,
  output logic               mem_busy,
  output logic               mem_rvalid,
  output logic [CWIDTH-1:0]  mem_rdata,
  output logic               clearing,
  output logic               err_drop
);
  localparam int CNT_W = (wr_busy > 1) ? $clog2(wr_busy) : 1;

  state_e             state_q, state_d;
  logic [logsize-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;

  logic               ram_we, ram_re;
  logic [logsize-1:0] ram_addr;
  logic [CWIDTH-1:0]  ram_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    rvalid_d  = 1'b0;
    err_d     = err_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = mem_addr;
    ram_wdata = mem_wdata;
    // Init overrides everything, including a coincident request.
    if (mem_init) begin
      state_d = ST_CLEAR;
      ptr_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_doit) begin
            if (mem_wselect) begin
              ram_we  = 1'b1;
              state_d = ST_WBUSY;
              cnt_d   = CNT_W'(wr_busy - 1);
            end else begin
              ram_re   = 1'b1;
              rvalid_d = 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          ram_we    = 1'b1;
          ram_addr  = ptr_q;
          ram_wdata = '0;
          ptr_d     = ptr_q + logsize'(1);
          if (&ptr_q) state_d = ST_IDLE;
          if (mem_doit) err_d = 1'b1;
        end
        ST_WBUSY: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
          if (mem_doit) err_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  bf_tape_ram #(.AW(logsize)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (mem_rdata)
  );

  assign mem_busy   = (state_q != ST_IDLE);
  assign clearing   = (state_q == ST_CLEAR);
  assign mem_rvalid = rvalid_q;
  assign err_drop   = err_q;
endmodule

// File: tb/tb_bf_tape_mem.sv
// Self-checking bench for bf_tape_mem against an array model of the tape.
module tb_bf_tape_mem;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_init;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wselect;
  logic       mem_doit;
  logic       mem_busy;
  logic       mem_rvalid;
  logic [7:0] mem_rdata;
  logic       clearing;
  logic       err_drop;

  logic [7:0] tape_m [128];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bf_tape_mem #(.logsize(7), .wr_busy(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_init    (mem_init),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wselect (mem_wselect),
    .mem_doit    (mem_doit),
    .mem_busy    (mem_busy),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .clearing    (clearing),
    .err_drop    (err_drop)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles from now until mem_busy drops (bounded).
  task automatic count_busy(output int n, output int rv_seen);
    n = 0;
    rv_seen = 0;
    while (mem_busy === 1'b1 && n < 1000) begin
      if (mem_rvalid !== 1'b0) rv_seen++;
      n++;
      step();
    end
  endtask

  // Counts sweep cycles; every sweep cycle must also show mem_busy.
  task automatic count_clear(output int n, output int bad_busy);
    n = 0;
    bad_busy = 0;
    while (clearing === 1'b1 && n < 1000) begin
      if (mem_busy !== 1'b1) bad_busy++;
      n++;
      step();
    end
  endtask

  task automatic pulse_init();
    mem_init = 1'b1;
    mem_doit = 1'b0;
    step();
    mem_init = 1'b0;
    for (int i = 0; i < 128; i++) tape_m[i] = 8'h00;
  endtask

  task automatic run_clear(input string tag);
    int n, bb;
    count_clear(n, bb);
    checks++;
    if (n !== 128 || bb !== 0) begin
      errors++;
      $display("FAIL %s sweep_len got %0d busy_gaps %0d want 128/0", tag, n, bb);
    end
    checks++;
    if (mem_busy !== 1'b0 || clearing !== 1'b0) begin
      errors++;
      $display("FAIL %s post_sweep_idle busy %b clearing %b want 0/0", tag, mem_busy, clearing);
    end
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, input string tag);
    int n, rv;
    mem_addr = a; mem_wdata = d; mem_wselect = 1'b1; mem_doit = 1'b1;
    step();
    mem_doit = 1'b0;
    tape_m[a] = d;
    count_busy(n, rv);
    checks++;
    if (n !== 8 || rv !== 0) begin
      errors++;
      $display("FAIL %s wbusy_len got %0d rvalid_hits %0d want 8/0", tag, n, rv);
    end
  endtask

  task automatic do_read(input logic [6:0] a, input string tag);
    mem_addr = a; mem_wselect = 1'b0; mem_doit = 1'b1;
    step();
    mem_doit = 1'b0;
    checks++;
    if (mem_rvalid !== 1'b1 || mem_rdata !== tape_m[a]) begin
      errors++;
      $display("FAIL %s read[%0d] rvalid %b data %h want 1/%h", tag, a, mem_rvalid, mem_rdata, tape_m[a]);
    end
    step();
    checks++;
    if (mem_rvalid !== 1'b0 || mem_rdata !== tape_m[a]) begin
      errors++;
      $display("FAIL %s hold[%0d] rvalid %b data %h want 0/%h", tag, a, mem_rvalid, mem_rdata, tape_m[a]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_init = 1'b0; mem_doit = 1'b0; mem_wselect = 1'b0;
    mem_addr = '0; mem_wdata = '0;
    step(); step();
    checks++;
    if ({mem_busy, mem_rvalid, clearing, err_drop} !== 4'b0 || mem_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset outs b/v/c/e %b%b%b%b data %h want 0000/00",
               mem_busy, mem_rvalid, clearing, err_drop, mem_rdata);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_init();
    pulse_init();
    run_clear("init");
    do_read(7'd0, "init");
    do_read(7'd5, "init");
    do_read(7'd127, "init");
  endtask

  task automatic test_write_recovery();
    do_write(7'd3, 8'h41, "wrec");
    do_read(7'd3, "wrec");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    do_write(7'd1, 8'h11, "b2b");
    do_write(7'd2, 8'h22, "b2b");
    do_write(7'd3, 8'h33, "b2b");
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    mem_wselect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_addr = 7'(i + 1); mem_doit = 1'b1;
      step();
      checks++;
      if (mem_rvalid !== 1'b1 || mem_rdata !== exp[i]) begin
        errors++;
        $display("FAIL b2b pipe%0d rvalid %b data %h want 1/%h", i, mem_rvalid, mem_rdata, exp[i]);
      end
    end
    mem_doit = 1'b0;
    step();
    checks++;
    if (mem_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b tail rvalid %b want 0", mem_rvalid);
    end
  endtask

  task automatic test_drop();
    int n, rv;
    mem_addr = 7'd4; mem_wdata = 8'h55; mem_wselect = 1'b1; mem_doit = 1'b1;
    step();
    tape_m[4] = 8'h55;
    mem_wdata = 8'h99;
    step();
    mem_doit = 1'b0;
    checks++;
    if (err_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop err_rise got %b want 1", err_drop);
    end
    count_busy(n, rv);
    checks++;
    if (n !== 7 || rv !== 0) begin
      errors++;
      $display("FAIL drop wbusy_rest got %0d rvalid_hits %0d want 7/0", n, rv);
    end
    do_read(7'd4, "drop");
    checks++;
    if (err_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop err_sticky got %b want 1", err_drop);
    end
    mem_doit = 1'b1; mem_wselect = 1'b1;
    mem_init = 1'b1;
    step();
    mem_init = 1'b0; mem_doit = 1'b0;
    for (int i = 0; i < 128; i++) tape_m[i] = 8'h00;
    checks++;
    if (err_drop !== 1'b0 || clearing !== 1'b1) begin
      errors++;
      $display("FAIL drop init_clear err %b clearing %b want 0/1", err_drop, clearing);
    end
    run_clear("drop");
  endtask

  task automatic test_init_mid();
    mem_addr = 7'd9; mem_wdata = 8'h5A; mem_wselect = 1'b1; mem_doit = 1'b1;
    step();
    mem_doit = 1'b0;
    step(); step();
    pulse_init();
    run_clear("mid_wbusy");
    for (int i = 0; i < 128; i++) tape_m[i] = 8'($urandom);
    for (int i = 0; i < 10; i++) do_write(7'($urandom_range(0, 127)), 8'hA5, "mid_fill");
    pulse_init();
    for (int i = 0; i < 40; i++) step();
    pulse_init();
    run_clear("mid_sweep");
    mem_wselect = 1'b0;
    for (int i = 0; i < 128; i++) begin
      mem_addr = 7'(i); mem_doit = 1'b1;
      step();
      checks++;
      if (mem_rvalid !== 1'b1 || mem_rdata !== 8'h00) begin
        errors++;
        $display("FAIL mid zero[%0d] rvalid %b data %h want 1/00", i, mem_rvalid, mem_rdata);
      end
    end
    mem_doit = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    do_write(7'd127, 8'hFF, "wrap");
    do_read(7'd127, "wrap");
    pulse_init();
    run_clear("wrap");
    do_read(7'd127, "wrap");
    do_read(7'd0, "wrap");
  endtask

  task automatic test_random();
    logic [6:0] a;
    for (int k = 0; k < 150; k++) begin
      a = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 2) == 0) do_write(a, 8'($urandom), "rand");
      else do_read(a, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_recovery();
    test_back_to_back();
    test_drop();
    test_init_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
